// File: rtl/sha2_k_stream.sv
// Streams SHA-2 round constants K[0..N-1] over a valid/ready handshake.
// A single 80x64 table serves both modes; SHA-256 uses the upper 32 bits of each row.
module sha2_k_stream #(
    parameter int SUPPORT_512 = 1,
    localparam int WORD_W = (SUPPORT_512 != 0) ? 64 : 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              mode,
    input  logic              abort,
    input  logic              k_ready,
    output logic              k_valid,
    output logic [WORD_W-1:0] k_data,
    output logic [6:0]        k_round,
    output logic              k_last,
    output logic              busy,
    output logic              done
);

    typedef enum logic {IDLE, RUN} state_t;

    state_t              state, state_n;
    logic                mode_r, mode_n;
    logic                valid_n, last_n, busy_n, done_n;
    logic [WORD_W-1:0]   data_n;
    logic [6:0]          round_n, round_inc, last_round;

    function automatic logic [63:0] k512(input logic [6:0] idx);
        case (idx)
            7'd0:  k512 = 64'h428a2f98d728ae22;  7'd1:  k512 = 64'h7137449123ef65cd;
            7'd2:  k512 = 64'hb5c0fbcfec4d3b2f;  7'd3:  k512 = 64'he9b5dba58189dbbc;
            7'd4:  k512 = 64'h3956c25bf348b538;  7'd5:  k512 = 64'h59f111f1b605d019;
            7'd6:  k512 = 64'h923f82a4af194f9b;  7'd7:  k512 = 64'hab1c5ed5da6d8118;
            7'd8:  k512 = 64'hd807aa98a3030242;  7'd9:  k512 = 64'h12835b0145706fbe;
            7'd10: k512 = 64'h243185be4ee4b28c;  7'd11: k512 = 64'h550c7dc3d5ffb4e2;
            7'd12: k512 = 64'h72be5d74f27b896f;  7'd13: k512 = 64'h80deb1fe3b1696b1;
            7'd14: k512 = 64'h9bdc06a725c71235;  7'd15: k512 = 64'hc19bf174cf692694;
            7'd16: k512 = 64'he49b69c19ef14ad2;  7'd17: k512 = 64'hefbe4786384f25e3;
            7'd18: k512 = 64'h0fc19dc68b8cd5b5;  7'd19: k512 = 64'h240ca1cc77ac9c65;
            7'd20: k512 = 64'h2de92c6f592b0275;  7'd21: k512 = 64'h4a7484aa6ea6e483;
            7'd22: k512 = 64'h5cb0a9dcbd41fbd4;  7'd23: k512 = 64'h76f988da831153b5;
            7'd24: k512 = 64'h983e5152ee66dfab;  7'd25: k512 = 64'ha831c66d2db43210;
            7'd26: k512 = 64'hb00327c898fb213f;  7'd27: k512 = 64'hbf597fc7beef0ee4;
            7'd28: k512 = 64'hc6e00bf33da88fc2;  7'd29: k512 = 64'hd5a79147930aa725;
            7'd30: k512 = 64'h06ca6351e003826f;  7'd31: k512 = 64'h142929670a0e6e70;
            7'd32: k512 = 64'h27b70a8546d22ffc;  7'd33: k512 = 64'h2e1b21385c26c926;
            7'd34: k512 = 64'h4d2c6dfc5ac42aed;  7'd35: k512 = 64'h53380d139d95b3df;
            7'd36: k512 = 64'h650a73548baf63de;  7'd37: k512 = 64'h766a0abb3c77b2a8;
            7'd38: k512 = 64'h81c2c92e47edaee6;  7'd39: k512 = 64'h92722c851482353b;
            7'd40: k512 = 64'ha2bfe8a14cf10364;  7'd41: k512 = 64'ha81a664bbc423001;
            7'd42: k512 = 64'hc24b8b70d0f89791;  7'd43: k512 = 64'hc76c51a30654be30;
            7'd44: k512 = 64'hd192e819d6ef5218;  7'd45: k512 = 64'hd69906245565a910;
            7'd46: k512 = 64'hf40e35855771202a;  7'd47: k512 = 64'h106aa07032bbd1b8;
            7'd48: k512 = 64'h19a4c116b8d2d0c8;  7'd49: k512 = 64'h1e376c085141ab53;
            7'd50: k512 = 64'h2748774cdf8eeb99;  7'd51: k512 = 64'h34b0bcb5e19b48a8;
            7'd52: k512 = 64'h391c0cb3c5c95a63;  7'd53: k512 = 64'h4ed8aa4ae3418acb;
            7'd54: k512 = 64'h5b9cca4f7763e373;  7'd55: k512 = 64'h682e6ff3d6b2b8a3;
            7'd56: k512 = 64'h748f82ee5defb2fc;  7'd57: k512 = 64'h78a5636f43172f60;
            7'd58: k512 = 64'h84c87814a1f0ab72;  7'd59: k512 = 64'h8cc702081a6439ec;
            7'd60: k512 = 64'h90befffa23631e28;  7'd61: k512 = 64'ha4506cebde82bde9;
            7'd62: k512 = 64'hbef9a3f7b2c67915;  7'd63: k512 = 64'hc67178f2e372532b;
            7'd64: k512 = 64'hca273eceea26619c;  7'd65: k512 = 64'hd186b8c721c0c207;
            7'd66: k512 = 64'heada7dd6cde0eb1e;  7'd67: k512 = 64'hf57d4f7fee6ed178;
            7'd68: k512 = 64'h06f067aa72176fba;  7'd69: k512 = 64'h0a637dc5a2c898a6;
            7'd70: k512 = 64'h113f9804bef90dae;  7'd71: k512 = 64'h1b710b35131c471b;
            7'd72: k512 = 64'h28db77f523047d84;  7'd73: k512 = 64'h32caab7b40c72493;
            7'd74: k512 = 64'h3c9ebe0a15c9bebc;  7'd75: k512 = 64'h431d67c49c100d4c;
            7'd76: k512 = 64'h4cc5d4becb3e42b6;  7'd77: k512 = 64'h597f299cfc657e2a;
            7'd78: k512 = 64'h5fcb6fab3ad6faec;  7'd79: k512 = 64'h6c44198c4a475817;
            default: k512 = '0;
        endcase
    endfunction

    // SHA-256 words are the upper halves, zero-extended; the 32-bit build keeps only those bits.
    function automatic logic [63:0] k_sel(input logic [6:0] idx, input logic m);
        logic [63:0] full;
        full = k512(idx);
        k_sel = m ? full : {32'h0, full[63:32]};
    endfunction

    assign round_inc  = k_round + 7'd1;
    assign last_round = mode_r ? 7'd79 : 7'd63;

    always_comb begin
        state_n = state;
        mode_n  = mode_r;
        round_n = k_round;
        data_n  = k_data;
        last_n  = k_last;
        valid_n = k_valid;
        busy_n  = busy;
        done_n  = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    mode_n  = (SUPPORT_512 != 0) ? mode : 1'b0;
                    round_n = '0;
                    data_n  = WORD_W'(k_sel(7'd0, mode_n));
                    last_n  = 1'b0;
                    valid_n = 1'b1;
                    busy_n  = 1'b1;
                    state_n = RUN;
                end
            end
            RUN: begin
                if (abort || (k_valid && k_ready && k_last)) begin
                    state_n = IDLE;
                    round_n = '0;
                    data_n  = '0;
                    last_n  = 1'b0;
                    valid_n = 1'b0;
                    busy_n  = 1'b0;
                    done_n  = !abort;
                end else if (k_valid && k_ready) begin
                    round_n = round_inc;
                    data_n  = WORD_W'(k_sel(round_inc, mode_r));
                    last_n  = (round_inc == last_round);
                end
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= IDLE;
            mode_r  <= 1'b0;
            k_round <= '0;
            k_data  <= '0;
            k_last  <= 1'b0;
            k_valid <= 1'b0;
            busy    <= 1'b0;
            done    <= 1'b0;
        end else begin
            state   <= state_n;
            mode_r  <= mode_n;
            k_round <= round_n;
            k_data  <= data_n;
            k_last  <= last_n;
            k_valid <= valid_n;
            busy    <= busy_n;
            done    <= done_n;
        end
    end

endmodule

// File: tb/tb_sha2_k_stream.sv
// Directed bench for sha2_k_stream: both modes, backpressure, abort, ignored start,
// asynchronous reset, and a 32-bit build.
module tb_sha2_k_stream;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0, mode = 1'b0, abort = 1'b0, k_ready = 1'b1;
    logic        k_valid, k_last, busy, done;
    logic [63:0] k_data;
    logic [6:0]  k_round;

    logic        start32 = 1'b0, mode32 = 1'b0, abort32 = 1'b0, k_ready32 = 1'b1;
    logic        k_valid32, k_last32, busy32, done32;
    logic [31:0] k_data32;
    logic [6:0]  k_round32;

    int compared = 0;
    int mismatched = 0;
    int last_seen;

    sha2_k_stream #(.SUPPORT_512(1)) u_dut (
        .clk(clk), .rst(rst), .start(start), .mode(mode), .abort(abort),
        .k_ready(k_ready), .k_valid(k_valid), .k_data(k_data), .k_round(k_round),
        .k_last(k_last), .busy(busy), .done(done)
    );

    sha2_k_stream #(.SUPPORT_512(0)) u_dut32 (
        .clk(clk), .rst(rst), .start(start32), .mode(mode32), .abort(abort32),
        .k_ready(k_ready32), .k_valid(k_valid32), .k_data(k_data32), .k_round(k_round32),
        .k_last(k_last32), .busy(busy32), .done(done32)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic start_run(input logic m);
        start = 1'b1;
        mode  = m;
        tick();
        start = 1'b0;
    endtask

    task automatic chk_idle(input string tag);
        chk({tag, "_valid"}, 64'(k_valid), 64'd0);
        chk({tag, "_busy"},  64'(busy),    64'd0);
        chk({tag, "_data"},  k_data,       64'd0);
        chk({tag, "_round"}, 64'(k_round), 64'd0);
        chk({tag, "_last"},  64'(k_last),  64'd0);
    endtask

    initial begin
        // Reset state
        tick();
        tick();
        chk_idle("rst");
        chk("rst_done", 64'(done), 64'd0);
        rst = 1'b0;
        tick();
        chk("idle_valid", 64'(k_valid), 64'd0);

        // 1: SHA-256 continuous ready
        k_ready = 1'b1;
        start_run(1'b0);
        chk("t1_busy", 64'(busy), 64'd1);
        chk("t1_k0", k_data, 64'h00000000_428a2f98);
        for (int i = 0; i < 64; i++) begin
            chk("t1_valid", 64'(k_valid), 64'd1);
            chk("t1_round", 64'(k_round), 64'(i));
            chk("t1_last", 64'(k_last), 64'(i == 63));
            if (i == 63) chk("t1_k63", k_data, 64'h00000000_c67178f2);
            tick();
        end
        chk("t1_done", 64'(done), 64'd1);
        chk_idle("t1_end");
        tick();
        chk("t1_done_clr", 64'(done), 64'd0);

        // 2: SHA-512 continuous ready
        start_run(1'b1);
        for (int i = 0; i < 80; i++) begin
            chk("t2_round", 64'(k_round), 64'(i));
            chk("t2_last", 64'(k_last), 64'(i == 79));
            if (i == 0)  chk("t2_k0",  k_data, 64'h428a2f98d728ae22);
            if (i == 63) chk("t2_k63", k_data, 64'hc67178f2e372532b);
            if (i == 64) chk("t2_k64", k_data, 64'hca273eceea26619c);
            if (i == 79) chk("t2_k79", k_data, 64'h6c44198c4a475817);
            tick();
        end
        chk("t2_done", 64'(done), 64'd1);
        chk("t2_valid", 64'(k_valid), 64'd0);
        tick();

        // 3: backpressure at round 10
        start_run(1'b0);
        for (int i = 0; i < 10; i++) tick();
        k_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("t3_hold_round", 64'(k_round), 64'd10);
            chk("t3_hold_data", k_data, 64'h00000000_243185be);
            chk("t3_hold_valid", 64'(k_valid), 64'd1);
        end
        k_ready = 1'b1;
        tick();
        chk("t3_round11", 64'(k_round), 64'd11);
        chk("t3_k11", k_data, 64'h00000000_550c7dc3);
        abort = 1'b1;
        tick();
        abort = 1'b0;
        chk("t3_abort_valid", 64'(k_valid), 64'd0);

        // 4: abort coincident with a beat at round 20
        start_run(1'b0);
        for (int i = 0; i < 20; i++) tick();
        chk("t4_round20", 64'(k_round), 64'd20);
        abort = 1'b1;
        tick();
        abort = 1'b0;
        chk("t4_valid", 64'(k_valid), 64'd0);
        chk("t4_busy", 64'(busy), 64'd0);
        chk("t4_done", 64'(done), 64'd0);
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("t4_no_done", 64'(done), 64'd0);
        end
        start_run(1'b0);
        chk("t4_restart_round", 64'(k_round), 64'd0);
        chk("t4_restart_k0", k_data, 64'h00000000_428a2f98);

        // 5: start ignored while busy, mode toggled mid-run
        for (int i = 0; i < 4; i++) tick();
        chk("t5_round4", 64'(k_round), 64'd4);
        tick();
        start = 1'b1;
        tick();
        start = 1'b0;
        chk("t5_round6", 64'(k_round), 64'd6);
        chk("t5_k6", k_data, 64'h00000000_923f82a4);
        mode = 1'b1;
        last_seen = -1;
        for (int n = 0; n < 100 && last_seen < 0; n++) begin
            if (k_valid && k_last) last_seen = int'(k_round);
            tick();
        end
        chk("t5_last_round", 64'(last_seen), 64'd63);
        chk("t5_done", 64'(done), 64'd1);
        mode = 1'b0;
        tick();

        // 6: asynchronous reset mid-cycle at round 40 of a SHA-512 run
        start_run(1'b1);
        for (int i = 0; i < 40; i++) tick();
        chk("t6_round40", 64'(k_round), 64'd40);
        #2 rst = 1'b1;
        #1;
        chk_idle("t6_async");
        chk("t6_async_done", 64'(done), 64'd0);
        tick();
        rst = 1'b0;
        for (int i = 0; i < 3; i++) tick();
        chk("t6_idle_valid", 64'(k_valid), 64'd0);
        chk("t6_idle_busy", 64'(busy), 64'd0);

        // 32-bit build: mode=1 is ignored and the run is 64 beats
        start32 = 1'b1;
        mode32  = 1'b1;
        tick();
        start32 = 1'b0;
        for (int i = 0; i < 64; i++) begin
            chk("w32_round", 64'(k_round32), 64'(i));
            chk("w32_last", 64'(k_last32), 64'(i == 63));
            if (i == 0)  chk("w32_k0",  64'(k_data32), 64'h428a2f98);
            if (i == 63) chk("w32_k63", 64'(k_data32), 64'hc67178f2);
            tick();
        end
        chk("w32_done", 64'(done32), 64'd1);
        chk("w32_valid", 64'(k_valid32), 64'd0);
        tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation exceeded time limit");
        $fatal(1, "timeout");
    end

endmodule
